// File: rtl/ltl_nfa_engine.sv
// Runtime-programmable homogeneous NFA (STE array) for LTL trace monitoring.
// Consumes a symbol stream and queues non-zero report vectors in a first-word-fall-through FIFO.
module ltl_nfa_engine #(
  parameter int unsigned N_STATES  = 16,
  parameter int unsigned SYM_W     = 8,
  parameter int unsigned RPT_DEPTH = 8,
  parameter int unsigned IDX_W     = 16,
  localparam int unsigned CFG_W    = (N_STATES > 2 * SYM_W) ? N_STATES : 2 * SYM_W,
  localparam int unsigned SEL_W    = (N_STATES > 1) ? $clog2(N_STATES) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [SEL_W-1:0]    cfg_sel,
  input  logic [1:0]          cfg_field,
  input  logic [CFG_W-1:0]    cfg_wdata,
  output logic                cfg_err,
  input  logic                sym_valid,
  output logic                sym_ready,
  input  logic [SYM_W-1:0]    sym_data,
  input  logic                sym_last,
  output logic                rpt_valid,
  input  logic                rpt_ready,
  output logic [N_STATES-1:0] rpt_vec,
  output logic [IDX_W-1:0]    rpt_idx,
  output logic [N_STATES-1:0] active
);

  localparam int unsigned PTR_W = $clog2(RPT_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Per-state configuration
  logic [SYM_W-1:0]    lo_q     [N_STATES];
  logic [SYM_W-1:0]    hi_q     [N_STATES];
  logic [N_STATES-1:0] mask_q   [N_STATES];
  logic [1:0]          start_q  [N_STATES];
  logic [N_STATES-1:0] report_q;

  logic [N_STATES-1:0] active_q;
  logic [IDX_W-1:0]    idx_q;
  logic                sof_q;
  logic                stream_q;
  logic                cfg_err_q;

  logic [N_STATES-1:0] fifo_vec [RPT_DEPTH];
  logic [IDX_W-1:0]    fifo_idx [RPT_DEPTH];
  logic [CNT_W-1:0]    wptr_q;
  logic [CNT_W-1:0]    rptr_q;

  logic [N_STATES-1:0] match;
  logic [N_STATES-1:0] enable;
  logic [N_STATES-1:0] next_active;
  logic [N_STATES-1:0] rv;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                accept;
  logic                push;
  logic                cfg_ok;
  logic                cfg_bad;

  always_comb begin
    match  = '0;
    enable = '0;
    for (int i = 0; i < N_STATES; i++) begin
      match[i]  = (sym_data >= lo_q[i]) && (sym_data <= hi_q[i]);
      enable[i] = (|(active_q & mask_q[i])) || (start_q[i] == 2'd1 && sof_q) ||
                  (start_q[i] == 2'd2);
    end
    next_active = enable & match;
    rv          = next_active & report_q;
  end

  // Extra pointer bit distinguishes full from empty when the indices coincide
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                      (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
  assign rpt_valid  = ~fifo_empty;
  assign pop        = rpt_valid & rpt_ready;
  assign sym_ready  = ~fifo_full | pop;
  assign accept     = sym_valid & sym_ready;
  assign push       = accept & (|rv);

  assign cfg_ok  = cfg_we & ~stream_q & ~accept & (cfg_field != 2'd3) &
                   (32'(cfg_sel) < N_STATES);
  assign cfg_bad = cfg_we & ~cfg_ok;

  assign rpt_vec = fifo_vec[rptr_q[PTR_W-1:0]];
  assign rpt_idx = fifo_idx[rptr_q[PTR_W-1:0]];
  assign active  = active_q;
  assign cfg_err = cfg_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q  <= '0;
      idx_q     <= '0;
      sof_q     <= 1'b1;
      stream_q  <= 1'b0;
      cfg_err_q <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      report_q  <= '0;
      for (int i = 0; i < N_STATES; i++) begin
        lo_q[i]    <= '1;
        hi_q[i]    <= '0;
        mask_q[i]  <= '0;
        start_q[i] <= '0;
      end
    end else begin
      cfg_err_q <= cfg_bad;
      if (accept) begin
        // The last symbol still reports, but the next stream starts from a clean slate
        active_q <= sym_last ? '0 : next_active;
        idx_q    <= sym_last ? '0 : idx_q + IDX_W'(1);
        sof_q    <= sym_last;
        stream_q <= ~sym_last;
      end
      if (push) wptr_q <= wptr_q + CNT_W'(1);
      if (pop)  rptr_q <= rptr_q + CNT_W'(1);
      if (cfg_ok) begin
        case (cfg_field)
          2'd0: begin
            lo_q[cfg_sel] <= cfg_wdata[SYM_W-1:0];
            hi_q[cfg_sel] <= cfg_wdata[2*SYM_W-1:SYM_W];
          end
          2'd1: mask_q[cfg_sel] <= cfg_wdata[N_STATES-1:0];
          2'd2: begin
            report_q[cfg_sel] <= cfg_wdata[2];
            start_q[cfg_sel]  <= cfg_wdata[1:0];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_vec[wptr_q[PTR_W-1:0]] <= rv;
      fifo_idx[wptr_q[PTR_W-1:0]] <= idx_q;
    end
  end

endmodule

// File: tb/tb_ltl_nfa_engine.sv
// Scoreboard bench for ltl_nfa_engine: directed streams push expected reports, a monitor
// compares every popped FIFO head in order.
module tb_ltl_nfa_engine;

  localparam int unsigned N_STATES  = 16;
  localparam int unsigned SYM_W     = 8;
  localparam int unsigned RPT_DEPTH = 8;
  localparam int unsigned IDX_W     = 16;
  localparam int unsigned CFG_W     = 16;
  localparam int unsigned SEL_W     = 4;

  typedef struct packed {
    logic [N_STATES-1:0] vec;
    logic [IDX_W-1:0]    idx;
  } rpt_t;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                cfg_we = 1'b0;
  logic [SEL_W-1:0]    cfg_sel = '0;
  logic [1:0]          cfg_field = '0;
  logic [CFG_W-1:0]    cfg_wdata = '0;
  logic                cfg_err;
  logic                sym_valid = 1'b0;
  logic                sym_ready;
  logic [SYM_W-1:0]    sym_data = '0;
  logic                sym_last = 1'b0;
  logic                rpt_valid;
  logic                rpt_ready = 1'b1;
  logic [N_STATES-1:0] rpt_vec;
  logic [IDX_W-1:0]    rpt_idx;
  logic [N_STATES-1:0] active;

  int   checks = 0;
  int   errors = 0;
  rpt_t exp_q[$];
  rpt_t mon_e;

  ltl_nfa_engine #(
    .N_STATES (N_STATES),
    .SYM_W    (SYM_W),
    .RPT_DEPTH(RPT_DEPTH),
    .IDX_W    (IDX_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_we   (cfg_we),
    .cfg_sel  (cfg_sel),
    .cfg_field(cfg_field),
    .cfg_wdata(cfg_wdata),
    .cfg_err  (cfg_err),
    .sym_valid(sym_valid),
    .sym_ready(sym_ready),
    .sym_data (sym_data),
    .sym_last (sym_last),
    .rpt_valid(rpt_valid),
    .rpt_ready(rpt_ready),
    .rpt_vec  (rpt_vec),
    .rpt_idx  (rpt_idx),
    .active   (active)
  );

  always #5 clk = ~clk;

  // Monitor: a pop happens on the next rising edge whenever valid&ready holds at the falling edge
  always @(negedge clk) begin
    if (!reset && rpt_valid && rpt_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_report got vec=%h idx=%0d, none expected", rpt_vec, rpt_idx);
      end else begin
        mon_e = exp_q.pop_front();
        if (rpt_vec !== mon_e.vec || rpt_idx !== mon_e.idx) begin
          errors++;
          $display("FAIL report got vec=%h idx=%0d, expected vec=%h idx=%0d",
                   rpt_vec, rpt_idx, mon_e.vec, mon_e.idx);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic expect_rpt(input logic [N_STATES-1:0] vec, input logic [IDX_W-1:0] idx);
    exp_q.push_back('{vec: vec, idx: idx});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic cfg_write(input logic [SEL_W-1:0] sel, input logic [1:0] field,
                           input logic [CFG_W-1:0] data);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_field = field;
    cfg_wdata = data;
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic send(input logic [SYM_W-1:0] data, input logic last);
    int n = 0;
    sym_valid = 1'b1;
    sym_data  = data;
    sym_last  = last;
    @(negedge clk);
    while (!sym_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!sym_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got sym_ready=0, expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1 sym_valid = 1'b0;
    sym_last = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((rpt_valid || exp_q.size() != 0) && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1;
    do_reset();
    check("rst_sym_ready", 32'(sym_ready), 32'd1);
    check("rst_rpt_valid", 32'(rpt_valid), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_active", 32'(active), 32'd0);

    // Chain S0 -> S1
    cfg_write(4'd0, 2'd0, {8'd63, 8'd0});
    cfg_write(4'd0, 2'd2, 16'h0001);
    cfg_write(4'd1, 2'd0, {8'd127, 8'd64});
    cfg_write(4'd1, 2'd1, 16'h0001);
    cfg_write(4'd1, 2'd2, 16'h0004);
    send(8'd10, 1'b0);
    check("chain_active_s0", 32'(active), 32'h1);
    expect_rpt(16'h0002, 16'd1);
    send(8'd100, 1'b1);
    check("chain_active_after_last", 32'(active), 32'd0);
    drain();

    // All-input start
    do_reset();
    cfg_write(4'd0, 2'd0, {8'd5, 8'd5});
    cfg_write(4'd0, 2'd2, 16'h0006);
    expect_rpt(16'h0001, 16'd0);
    send(8'd5, 1'b0);
    send(8'd1, 1'b0);
    check("allin_no_match_active", 32'(active), 32'd0);
    expect_rpt(16'h0001, 16'd2);
    send(8'd5, 1'b0);
    expect_rpt(16'h0001, 16'd3);
    send(8'd5, 1'b1);
    drain();

    // Backpressure
    do_reset();
    cfg_write(4'd0, 2'd0, {8'd255, 8'd0});
    cfg_write(4'd0, 2'd2, 16'h0006);
    rpt_ready = 1'b0;
    for (int i = 0; i < 9; i++) expect_rpt(16'h0001, 16'(i));
    for (int i = 0; i < 8; i++) send(8'(i), 1'b0);
    sym_valid = 1'b1;
    sym_data  = 8'd8;
    sym_last  = 1'b1;
    @(negedge clk);
    check("bp_sym_ready_full", 32'(sym_ready), 32'd0);
    check("bp_rpt_valid_full", 32'(rpt_valid), 32'd1);
    @(posedge clk);
    #1 rpt_ready = 1'b1;
    @(negedge clk);
    check("bp_sym_ready_on_pop", 32'(sym_ready), 32'd1);
    @(posedge clk);
    #1 sym_valid = 1'b0;
    sym_last = 1'b0;
    drain();

    // Config guard
    do_reset();
    cfg_write(4'd0, 2'd0, {8'd255, 8'd0});
    cfg_write(4'd0, 2'd2, 16'h0001);
    send(8'd7, 1'b0);
    cfg_write(4'd0, 2'd2, 16'h0005);
    check("guard_err_mid_stream", 32'(cfg_err), 32'd1);
    send(8'd8, 1'b0);
    check("guard_err_clears", 32'(cfg_err), 32'd0);
    check("guard_active_no_loop", 32'(active), 32'd0);
    send(8'd9, 1'b1);
    cfg_write(4'd0, 2'd2, 16'h0005);
    check("guard_err_idle", 32'(cfg_err), 32'd0);
    cfg_write(4'd2, 2'd3, 16'hFFFF);
    check("guard_err_field3", 32'(cfg_err), 32'd1);
    expect_rpt(16'h0001, 16'd0);
    send(8'd3, 1'b1);
    drain();

    // Self-loop with start-of-data, two streams
    do_reset();
    cfg_write(4'd0, 2'd0, {8'd255, 8'd0});
    cfg_write(4'd0, 2'd1, 16'h0001);
    cfg_write(4'd0, 2'd2, 16'h0005);
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 3; i++) begin
        expect_rpt(16'h0001, 16'(i));
        send(8'(i + 1), i == 2);
      end
    end
    drain();

    // Reset with pending reports
    do_reset();
    cfg_write(4'd0, 2'd0, {8'd255, 8'd0});
    cfg_write(4'd0, 2'd2, 16'h0006);
    rpt_ready = 1'b0;
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    send(8'd3, 1'b0);
    check("pre_rst_rpt_valid", 32'(rpt_valid), 32'd1);
    check("pre_rst_active", 32'(active), 32'h1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_rpt_valid", 32'(rpt_valid), 32'd0);
    check("mid_rst_active", 32'(active), 32'd0);
    check("mid_rst_sym_ready", 32'(sym_ready), 32'd1);
    reset = 1'b0;
    rpt_ready = 1'b1;
    send(8'd4, 1'b0);
    check("post_rst_no_match", 32'(active), 32'd0);
    repeat (2) @(posedge clk);
    #1 check("post_rst_no_report", 32'(rpt_valid), 32'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
